// File: rtl/name_entry_pkg.sv
// Shared constants and types for the keyboard-driven team-name editor.
package name_entry_pkg;

  localparam int unsigned NAME_LEN = 8;
  localparam int unsigned ADDR_W   = $clog2(NAME_LEN);
  localparam int unsigned LEN_W    = $clog2(NAME_LEN + 1);

  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(NAME_LEN);

  // State codes kept as plain constants so the state register stays a bare vector.
  localparam logic [1:0] ST_CLEAR  = 2'd0;
  localparam logic [1:0] ST_EDIT   = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [1:0] ST_CURSOR = 2'd3;

  typedef enum logic [1:0] {
    NeClear  = ST_CLEAR,
    NeEdit   = ST_EDIT,
    NeDone   = ST_DONE,
    NeCursor = ST_CURSOR
  } ne_state_t;

  localparam logic [7:0] HID_A     = 8'h04;
  localparam logic [7:0] HID_Z     = 8'h1D;
  localparam logic [7:0] HID_1     = 8'h1E;
  localparam logic [7:0] HID_0     = 8'h27;
  localparam logic [7:0] HID_ENTER = 8'h28;
  localparam logic [7:0] HID_ESC   = 8'h29;
  localparam logic [7:0] HID_BKSP  = 8'h2A;
  localparam logic [7:0] HID_SPACE = 8'h2C;

  localparam logic [6:0] ASCII_NUL     = 7'h00;
  localparam logic [6:0] ASCII_CURSOR  = 7'h5F;
  localparam logic [6:0] ASCII_SPACE   = 7'h20;
  localparam logic [6:0] ASCII_ZERO    = 7'h30;
  localparam logic [6:0] ASCII_ONE     = 7'h31;
  localparam logic [6:0] ASCII_UPPER_A = 7'h41;
  localparam logic [6:0] ASCII_LOWER_A = 7'h61;

endpackage

// File: rtl/name_entry_ctrl_hid_to_ascii.sv
// Combinational USB HID keycode to 7-bit ASCII decoder with control-key flags.
module hid_to_ascii
  import name_entry_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  output logic [6:0] ascii,
  output logic       printable,
  output logic       is_bksp,
  output logic       is_enter,
  output logic       is_esc
);

  always_comb begin
    ascii     = ASCII_NUL;
    printable = 1'b0;
    if (code >= HID_A && code <= HID_Z) begin
      ascii     = (shift ? ASCII_UPPER_A : ASCII_LOWER_A) + 7'(code - HID_A);
      printable = 1'b1;
    end else if (code >= HID_1 && code < HID_0) begin
      ascii     = ASCII_ONE + 7'(code - HID_1);
      printable = 1'b1;
    end else if (code == HID_0) begin
      ascii     = ASCII_ZERO;
      printable = 1'b1;
    end else if (code == HID_SPACE) begin
      ascii     = ASCII_SPACE;
      printable = 1'b1;
    end
  end

  assign is_bksp  = (code == HID_BKSP);
  assign is_enter = (code == HID_ENTER);
  assign is_esc   = (code == HID_ESC);

endmodule

// File: rtl/name_entry_ctrl.sv
// Keyboard editor for the 8-cell team name register: press detect, ASCII writes, length tracking.
// Optional underscore cursor at cell len is enabled by defining NAME_ENTRY_CURSOR_EN.
module name_entry_ctrl
  import name_entry_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic [7:0]        key_code,
  input  logic              key_shift,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_address,
  output logic [6:0]        wr_data,
  output logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              name_done
);

`ifdef NAME_ENTRY_CURSOR_EN
  localparam logic [6:0] EMPTY_CHAR = ASCII_CURSOR;
`else
  localparam logic [6:0] EMPTY_CHAR = ASCII_NUL;
`endif

  logic [1:0]        state_q, state_d;
  logic [7:0]        prev_code_q, prev_code_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              name_done_q, name_done_d;
  logic              busy_q, busy_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_address_q, wr_address_d;
  logic [6:0]        wr_data_q, wr_data_d;

  logic [6:0] key_ascii;
  logic       key_printable, key_bksp, key_enter, key_esc;
  logic       key_event, take, start_clear, sweep_wr;

  hid_to_ascii u_hid_to_ascii (
    .code      (key_code),
    .shift     (key_shift),
    .ascii     (key_ascii),
    .printable (key_printable),
    .is_bksp   (key_bksp),
    .is_enter  (key_enter),
    .is_esc    (key_esc)
  );

  // busy_q also covers the final sweep/cursor write cycle, so gating on it drops
  // every press that arrives while the display is being rewritten.
  assign key_event = (key_code != 8'h00) && (key_code != prev_code_q);
  assign take      = key_event && !busy_q;

  always_comb begin
    prev_code_d  = key_code;
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    len_d        = len_q;
    name_done_d  = name_done_q;
    wr_en_d      = 1'b0;
    wr_address_d = wr_address_q;
    wr_data_d    = wr_data_q;
    sweep_wr     = 1'b0;
    start_clear  = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        wr_en_d      = 1'b1;
        wr_address_d = clr_addr_q;
        wr_data_d    = ASCII_NUL;
        sweep_wr     = 1'b1;
        len_d        = '0;
        clr_addr_d   = clr_addr_q + 1'b1;
        if (clr_addr_q == ADDR_W'(NAME_LEN - 1)) begin
`ifdef NAME_ENTRY_CURSOR_EN
          state_d = ST_CURSOR;
`else
          state_d = ST_EDIT;
`endif
        end
      end
`ifdef NAME_ENTRY_CURSOR_EN
      ST_CURSOR: begin
        wr_en_d      = 1'b1;
        wr_address_d = ADDR_W'(len_q);
        wr_data_d    = ASCII_CURSOR;
        sweep_wr     = 1'b1;
        state_d      = ST_EDIT;
      end
`endif
      ST_EDIT: begin
        if (take) begin
          if (key_esc) begin
            start_clear = 1'b1;
          end else if (key_printable) begin
            if (len_q != LEN_FULL) begin
              wr_en_d      = 1'b1;
              wr_address_d = ADDR_W'(len_q);
              wr_data_d    = key_ascii;
              len_d        = len_q + 1'b1;
`ifdef NAME_ENTRY_CURSOR_EN
              if (len_d != LEN_FULL) state_d = ST_CURSOR;
`endif
            end
          end else if (key_bksp) begin
            if (len_q != '0) begin
              len_d        = len_q - 1'b1;
              wr_en_d      = 1'b1;
              wr_address_d = ADDR_W'(len_d);
              wr_data_d    = EMPTY_CHAR;
            end
          end else if (key_enter) begin
            if (len_q != '0) begin
              state_d     = ST_DONE;
              name_done_d = 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        if (take && key_esc) start_clear = 1'b1;
      end
      default: state_d = ST_CLEAR;
    endcase

    // Escape issues the address-0 clear write itself so the sweep starts one cycle after the press.
    if (start_clear) begin
      state_d      = ST_CLEAR;
      clr_addr_d   = ADDR_W'(1);
      len_d        = '0;
      name_done_d  = 1'b0;
      wr_en_d      = 1'b1;
      wr_address_d = '0;
      wr_data_d    = ASCII_NUL;
      sweep_wr     = 1'b1;
    end

    busy_d = (state_d == ST_CLEAR) || (state_d == ST_CURSOR) || sweep_wr;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_CLEAR;
      prev_code_q  <= 8'h00;
      clr_addr_q   <= '0;
      len_q        <= '0;
      name_done_q  <= 1'b0;
      busy_q       <= 1'b1;
      wr_en_q      <= 1'b0;
      wr_address_q <= '0;
      wr_data_q    <= ASCII_NUL;
    end else begin
      state_q      <= state_d;
      prev_code_q  <= prev_code_d;
      clr_addr_q   <= clr_addr_d;
      len_q        <= len_d;
      name_done_q  <= name_done_d;
      busy_q       <= busy_d;
      wr_en_q      <= wr_en_d;
      wr_address_q <= wr_address_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_address = wr_address_q;
  assign wr_data    = wr_data_q;
  assign len        = len_q;
  assign busy       = busy_q;
  assign name_done  = name_done_q;

endmodule

// File: doc/name_entry_ctrl.md
# name_entry_ctrl

Keyboard-driven editor for the 8-character on-screen team name. Takes the level-held USB HID keycode from the keyboard interface, detects new key presses, converts them to 7-bit ASCII and issues single-cycle writes into the 8-entry name register file (its `data_In` / `wr_address` / `we` port). It also handles backspace, clear (Escape) and commit (Enter), and tracks the name length for the HUD logic.

## Interface
- `NAME_LEN`, 8: character cells in the name register; address width is `$clog2(NAME_LEN)`.
- `Clk`  in  1  system clock.
- `Reset`  in  1  reset, synchronous, active-high; clock `Clk`.
- `key_code`  in  8  HID keycode currently held, 0 = none.
- `key_shift`  in  1  shift modifier level.
- `wr_en`  out  1  write strobe to name register `we`.
- `wr_address`  out  3  cell index.
- `wr_data`  out  7  ASCII char code.
- `len`  out  4  committed character count, 0..8.
- `busy`  out  1  high in CLEAR and CURSOR; presses are dropped.
- `name_done`  out  1  high after a valid Enter, until Escape.

## Operation
- Press detect: `prev_code` register. Event when `key_code != 0 && key_code != prev_code`. Held keys produce one event only. `prev_code` updates every cycle.
- HID map:
  - 0x04–0x1D → 'a'–'z' (0x61+); with `key_shift` → 'A'–'Z' (0x41+).
  - 0x1E–0x26 → '1'–'9'.
  - 0x27 → '0'.
  - 0x2C → space (0x20).
  - Controls: 0x2A BACKSPACE, 0x28 ENTER, 0x29 ESCAPE.
  - All other codes are ignored.
- States:
  - CLEAR: writes 0x00 to addresses 0..7, one per cycle. With the cursor option it then goes to CURSOR (addr 0); otherwise to EDIT. `len` := 0.
  - EDIT, printable event, `len<8`: write char at `len`, `len++`. With the cursor option, go to CURSOR for `len` if the new `len<8`. At `len==8`: ignored.
  - EDIT, BACKSPACE, `len>0`: `len--`, write 0x00 at new `len` (`len` is the old value minus 1). With the cursor option, write '_' there instead, no second cycle. At `len==0`: ignored.
  - EDIT, ENTER, `len>0`: go to DONE, `name_done`=1. At `len==0`: ignored.
  - ESCAPE from EDIT or DONE: go to CLEAR, `name_done`=0.
  - DONE: all other events ignored; the register contents are frozen.
  - CURSOR (option only): one write of '_' (0x5F) at `len`, then EDIT.
- `wr_en`, `wr_address` and `wr_data` are registered and change together. `wr_en` is 0 in idle cycles, where address and data hold their last values.

## Timing
- Reset: state → CLEAR. Outputs at reset: `wr_en`=0, `wr_address`=0, `wr_data`=0, `len`=0, `busy`=1, `name_done`=0.
  - The first clear write (`wr_en`=1, addr 0, data 0) is on the first cycle after `Reset` deasserts.
  - `busy` falls after 8 cycles, or 9 with the cursor option.
- Event sampled at edge k → `wr_en` high in cycle k+1.
- Cursor write, when used, follows in cycle k+2. `busy` is high during that cycle.
- `len` updates in the same cycle `wr_en` rises.
- An event arriving while `busy`=1 is lost, not queued. Keyboard rates make this harmless.
- `Reset` mid-CLEAR or mid-CURSOR restarts the CLEAR sweep at address 0.
- `name_done` rises in cycle k+1 after the Enter event.

## Configuration
- `NAME_ENTRY_CURSOR_EN` defined: an underscore cursor is maintained at cell `len` whenever `len<8`. This adds the CURSOR state and changes backspace to write '_'.
- Undefined: no CURSOR state. Empty cells are always 0x00, and every edit is exactly one write.

## Structure
- `name_entry_pkg` holds:
  - state enum `ne_state_t`;
  - HID constants (`HID_A`, `HID_Z`, `HID_1`, `HID_0`, `HID_ENTER`, `HID_ESC`, `HID_BKSP`, `HID_SPACE`);
  - ASCII constants (`ASCII_CURSOR`=7'h5F, `ASCII_NUL`);
  - `NAME_LEN`.
- Sub-module `hid_to_ascii` is purely combinational: `code` and `shift` in; `ascii[6:0]`, `printable`, `is_bksp`, `is_enter`, `is_esc` out.

## Test plan
- Reset then release → 8 writes of 0x00 to addresses 0..7 on consecutive cycles, `busy` low after them, `len`=0. With the cursor option, a ninth write of 0x5F at addr 0.
- Hold `key_code`=0x04 for 20 cycles, shift low → exactly one write of 0x61 at addr 0, `len`=1. Repeat with shift high → 0x41 at addr 1.
- Type 9 letters → addresses 0..7 written, ninth press produces no write, `len`=8. Backspace → write 0x00 at addr 7 (0x5F with the cursor option), `len`=7.
- Backspace at `len`=0 and Enter at `len`=0 → no write, no state change.
- Type "ab", Enter → `name_done`=1. Further letters and backspace → no writes. Escape → 8-cycle clear, `name_done`=0, `len`=0.
- Press during CLEAR → dropped. Assert `Reset` at clear address 4 → the sweep restarts at address 0.
